// File: rtl/masked_random_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | masked_random_feeder: seeded xorshift64 source of fresh mask randomness   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module masked_random_feeder #(
  parameter int          NUM_RANDOM      = 18,
  parameter int          WARMUP_CYCLES   = 16,
  parameter logic [63:0] ZERO_SEED_SUBST = 64'h9E3779B97F4A7C15
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic [63:0]           in_seed,
  input  logic                  in_seed_valid,
  output logic                  out_seed_ready,
  input  logic                  in_enable,
  output logic [NUM_RANDOM-1:0] out_random,
  output logic                  out_valid,
  output logic                  out_busy
);

  if (NUM_RANDOM < 1 || NUM_RANDOM > 64) begin : g_bad_num_random
    $fatal(1, "masked_random_feeder: NUM_RANDOM must be in 1..64");
  end
  if (WARMUP_CYCLES < 0 || WARMUP_CYCLES > 255) begin : g_bad_warmup
    $fatal(1, "masked_random_feeder: WARMUP_CYCLES must be in 0..255");
  end

  localparam logic [7:0] c_warmup = 8'(WARMUP_CYCLES);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t      r_fsm;
  logic [63:0] r_x;
  logic [7:0]  r_cnt;
  logic [63:0] w_x_next;
  logic [63:0] w_seed_eff;

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  assign w_x_next   = xs(r_x);
  assign w_seed_eff = (in_seed == 64'd0) ? ZERO_SEED_SUBST : in_seed;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_fsm <= ST_UNSEEDED;
      r_x   <= 64'd0;
      r_cnt <= 8'd0;
    end else begin
      case (r_fsm)
        ST_UNSEEDED: begin
          if (in_seed_valid) begin
            r_x   <= w_seed_eff;
            r_cnt <= c_warmup;
            r_fsm <= (c_warmup == 8'd0) ? ST_RUN : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          r_x   <= w_x_next;
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_fsm <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A reseed takes priority over consuming the current word.
          if (in_seed_valid) begin
            r_x   <= w_seed_eff;
            r_cnt <= c_warmup;
            r_fsm <= (c_warmup == 8'd0) ? ST_RUN : ST_WARMUP;
          end else if (in_enable) begin
            r_x <= w_x_next;
          end
        end
        default: begin
          r_fsm <= ST_UNSEEDED;
          r_x   <= 64'd0;
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign out_valid      = (r_fsm == ST_RUN);
  assign out_busy       = (r_fsm == ST_WARMUP);
  assign out_seed_ready = (r_fsm != ST_WARMUP);
  assign out_random     = out_valid ? r_x[NUM_RANDOM-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_masked_random_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_masked_random_feeder: directed scoreboard bench for two configurations |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_masked_random_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: NUM_RANDOM=64, WARMUP_CYCLES=0
  logic        rst0, sv0, en0, ready0, valid0, busy0;
  logic [63:0] seed0, rnd0;
  // dut1: NUM_RANDOM=18, WARMUP_CYCLES=16
  logic        rst1, sv1, en1, ready1, valid1, busy1;
  logic [63:0] seed1;
  logic [17:0] rnd1;

  masked_random_feeder #(.NUM_RANDOM(64), .WARMUP_CYCLES(0)) dut0 (
    .in_clock(clk), .in_reset(rst0), .in_seed(seed0), .in_seed_valid(sv0),
    .out_seed_ready(ready0), .in_enable(en0), .out_random(rnd0),
    .out_valid(valid0), .out_busy(busy0)
  );

  masked_random_feeder #(.NUM_RANDOM(18), .WARMUP_CYCLES(16)) dut1 (
    .in_clock(clk), .in_reset(rst1), .in_seed(seed1), .in_seed_valid(sv1),
    .out_seed_ready(ready1), .in_enable(en1), .out_random(rnd1),
    .out_valid(valid1), .out_busy(busy1)
  );

  localparam logic [63:0] M18 = 64'h3FFFF;
  localparam logic [63:0] S2  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] S3  = 64'h0F0F0F0F_A5A5A5A5;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] x;

  function automatic logic [63:0] xs_m(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [63:0] xs_n(input logic [63:0] v, input int n);
    logic [63:0] t;
    t = v;
    for (int k = 0; k < n; k++) t = xs_m(t);
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, obs);
    end else begin
      e = sb.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst0 = 1'b0; sv0 = 1'b0; en0 = 1'b0; seed0 = '0;
    rst1 = 1'b0; sv1 = 1'b0; en1 = 1'b0; seed1 = '0;
    #1;
    check("rst0_valid", {63'd0, valid0}, 64'd0);
    check("rst0_random", rnd0, 64'd0);
    check("rst0_busy", {63'd0, busy0}, 64'd0);
    check("rst0_ready", {63'd0, ready0}, 64'd1);
    check("rst1_valid", {63'd0, valid1}, 64'd0);
    check("rst1_random", {46'd0, rnd1}, 64'd0);
    check("rst1_ready", {63'd0, ready1}, 64'd1);
    cyc();
    rst0 = 1'b1; rst1 = 1'b1;

    // Enable while unseeded must not produce anything
    en0 = 1'b1; cyc(); en0 = 1'b0;
    check("d0_unseeded_valid", {63'd0, valid0}, 64'd0);

    // dut0: no warm-up, seed shows up unstepped
    seed0 = 64'd1; sv0 = 1'b1; sb.push_back(64'd1);
    cyc(); sv0 = 1'b0;
    sb_check("d0_seed1", rnd0);
    check("d0_valid", {63'd0, valid0}, 64'd1);
    en0 = 1'b1; sb.push_back(64'h40822041);
    cyc(); en0 = 1'b0;
    sb_check("d0_step1", rnd0);
    seed0 = 64'd0; sv0 = 1'b1; en0 = 1'b1; sb.push_back(64'h9E3779B97F4A7C15);
    cyc(); sv0 = 1'b0; en0 = 1'b0;
    sb_check("d0_zero_seed", rnd0);
    check("d0_valid_after_reseed", {63'd0, valid0}, 64'd1);
    #2 rst0 = 1'b0;
    #1 check("d0_async_rst_random", rnd0, 64'd0);
    check("d0_async_rst_valid", {63'd0, valid0}, 64'd0);
    cyc(); rst0 = 1'b1;

    // dut1: warm-up with a second seed held valid throughout
    seed1 = 64'd1; sv1 = 1'b1;
    cyc();
    seed1 = S2;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("d1_wu_busy%0d", i), {63'd0, busy1}, 64'd1);
      check($sformatf("d1_wu_ready%0d", i), {63'd0, ready1}, 64'd0);
      check($sformatf("d1_wu_valid%0d", i), {63'd0, valid1}, 64'd0);
      cyc();
    end
    sb.push_back(xs_n(64'd1, 16) & M18);
    sb_check("d1_xs16_seed1", {46'd0, rnd1});
    check("d1_run_valid", {63'd0, valid1}, 64'd1);
    check("d1_run_busy", {63'd0, busy1}, 64'd0);
    check("d1_run_ready", {63'd0, ready1}, 64'd1);
    cyc(); sv1 = 1'b0;
    check("d1_held_seed_taken", {63'd0, busy1}, 64'd1);
    en1 = 1'b1;
    for (int i = 0; i < 16; i++) cyc();
    en1 = 1'b0;
    x = xs_n(S2, 16);
    sb.push_back(x & M18);
    sb_check("d1_xs16_s2", {46'd0, rnd1});

    // Hold: word stays put while not consumed
    for (int i = 0; i < 10; i++) begin
      sb.push_back(x & M18);
      cyc();
      sb_check($sformatf("d1_hold%0d", i), {46'd0, rnd1});
    end
    en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = xs_m(x);
      sb.push_back(x & M18);
      cyc();
      sb_check($sformatf("d1_step%0d", i), {46'd0, rnd1});
    end

    // Reseed with simultaneous enable: seed loads, not stepped
    seed1 = S3; sv1 = 1'b1;
    cyc(); sv1 = 1'b0; en1 = 1'b0;
    check("d1_reseed_busy", {63'd0, busy1}, 64'd1);
    check("d1_reseed_valid", {63'd0, valid1}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      check($sformatf("d1_rs_valid%0d", i), {63'd0, valid1}, 64'd0);
    end
    cyc();
    sb.push_back(xs_n(S3, 16) & M18);
    sb_check("d1_xs16_s3", {46'd0, rnd1});

    // Asynchronous reset mid-run
    #2 rst1 = 1'b0;
    #1 check("d1_rst_run_valid", {63'd0, valid1}, 64'd0);
    check("d1_rst_run_random", {46'd0, rnd1}, 64'd0);
    check("d1_rst_run_ready", {63'd0, ready1}, 64'd1);
    cyc(); rst1 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("d1_post_rst_valid%0d", i), {63'd0, valid1}, 64'd0);
    end
    en1 = 1'b0;

    // Asynchronous reset mid-warm-up
    seed1 = S3; sv1 = 1'b1;
    cyc(); sv1 = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("d1_mid_wu_busy", {63'd0, busy1}, 64'd1);
    #2 rst1 = 1'b0;
    #1 check("d1_rst_wu_busy", {63'd0, busy1}, 64'd0);
    check("d1_rst_wu_ready", {63'd0, ready1}, 64'd1);
    check("d1_rst_wu_valid", {63'd0, valid1}, 64'd0);
    cyc(); rst1 = 1'b1;

    // Recovery after reset: full warm-up from a fresh seed
    seed1 = 64'd5; sv1 = 1'b1;
    cyc(); sv1 = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    sb.push_back(xs_n(64'd5, 16) & M18);
    sb_check("d1_recover", {46'd0, rnd1});
    check("d1_recover_valid", {63'd0, valid1}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
